md_readback_packer: RTL and testbench
=====================================

Name: md_readback_packer

Overview:
- Downstream drain stage for MD_Wrapper. After a timestep completes, it pulls every particle record out through the read_ctrl/elem_read handshake.
- Each 192-bit record is tagged with its particle index and the step number. The result is emitted as a 256-bit word on a valid/ready stream toward host/DMA.
- Replaces testbench-driven read_ctrl toggling with a self-timed, back-pressure-aware engine.

Parameters:
- REC_W, 192, width of MD_Wrapper d_out particle record
- OUT_W, 256, output stream word width
- IDX_W, 16, particle index/count width
- TIMEOUT, 1024, max cycles to wait for elem_read after a read_ctrl pulse

Ports:
- ap_clk  in  1  sole clock
- ap_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin draining n_particles records
- n_particles  in  IDX_W  record count, sampled on accepted start
- step  in  32  timestep tag, sampled on accepted start
- read_ctrl  out  1  one-cycle request pulse to MD_Wrapper
- elem_read  in  1  MD_Wrapper response strobe; d_out valid this cycle
- d_out  in  REC_W  particle record from MD_Wrapper
- m_tdata  out  OUT_W  packed output word
- m_tvalid  out  1  output word valid
- m_tready  in  1  downstream accept
- m_tlast  out  1  marks last record of the drain
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of drain
- err  out  1  sticky: timeout or spurious elem_read; cleared by next accepted start

Behaviour:
- Reset (asynchronous, any state): state=IDLE. read_ctrl, m_tvalid, m_tlast, busy, done, err all 0; m_tdata 0; index counter 0.
- FSM states: IDLE, REQ, WAIT, SEND, FIN.
- IDLE
  - start accepted: latch n_particles, step; clear idx and err; busy=1.
  - If n_particles==0: go to FIN, with no read_ctrl issued. Otherwise go to REQ.
- REQ: read_ctrl=1 for exactly this cycle; timeout counter cleared; go to WAIT.
- WAIT
  - elem_read=1: capture m_tdata = {16'h0, step[31:0], idx[15:0], d_out[191:0]}, i.e. record in [191:0], idx in [207:192], step in [239:208], zero in [255:240]. Set m_tvalid=1 next cycle; m_tlast=(idx==n_particles-1); go to SEND.
  - elem_read in the same cycle as read_ctrl is not possible; minimum response latency is 1 cycle.
  - Timeout counter reaches TIMEOUT-1 with no elem_read: err=1, m_tvalid stays 0, go to FIN (abort).
- SEND
  - m_tdata/m_tvalid/m_tlast held stable while m_tready=0.
  - On m_tvalid&m_tready: m_tvalid=0; idx+1.
  - If this was the last record, go to FIN; otherwise go to REQ.
- FIN: done=1 one cycle, busy=0, go to IDLE.
- Gap guarantee: read_ctrl pulses separated by at least 2 low cycles.
- Latency:
  - start (cycle 0) → read_ctrl (cycle 1).
  - elem_read (cycle k) → m_tvalid (cycle k+1).
  - Handshake (cycle j) → next read_ctrl (cycle j+1).
- Spurious events:
  - elem_read outside WAIT: ignored for data, sets err.
  - start while busy: ignored; latched n_particles/step unchanged.
- Counters: idx is IDX_W bits, so n_particles up to 65535; no wrap within a drain.
- Reset mid-drain: immediate return to IDLE. Any pending MD_Wrapper response after reset is ignored and does not set err, because err is cleared by reset and elem_read in IDLE is checked only while busy.

Decomposition:
- md_pkg holds:
  - REC_W, OUT_W, IDX_W
  - output field offsets: REC_LSB=0, IDX_LSB=192, STEP_LSB=208, PAD_LSB=240
  - state enum
  - pack function for the output word
- A small sub-module md_rb_timeout (loadable down-counter with expire flag) is natural.
- FSM and output register stay in md_readback_packer.

Test Plan:
- Reset asserted mid-SEND with m_tvalid=1 → all outputs 0 asynchronously; after release, start with n_particles=2 drains cleanly, err=0.
- start, n_particles=3, step=1; model responds elem_read 2 cycles after each read_ctrl; m_tready=1 → exactly 3 read_ctrl pulses and 3 words.
  - Words carry idx 0,1,2 in [207:192] and step 1 in [239:208].
  - m_tlast only on idx 2; one done pulse; busy low afterwards.
- Same run with m_tready held 0 for 10 cycles on word 1 → m_tdata stable throughout; no read_ctrl issued until accept; idx 2 follows normally.
- n_particles=0 → no read_ctrl, no m_tvalid; done pulses 2 cycles after start.
- Model never answers second read_ctrl; TIMEOUT=16 → err=1, done pulses, only 1 word emitted; next start clears err.
- elem_read pulsed while in SEND plus start pulsed while busy → err=1, output data unaffected, drain count unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared widths, output word layout, drain FSM states and the word packer
// used by the MD_Wrapper readback drain.
package md_pkg;

  localparam int REC_W  = 192;
  localparam int OUT_W  = 256;
  localparam int IDX_W  = 16;
  localparam int STEP_W = 32;

  localparam int REC_LSB  = 0;
  localparam int IDX_LSB  = 192;
  localparam int STEP_LSB = 208;
  localparam int PAD_LSB  = 240;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_FIN
  } md_state_t;

  function automatic logic [OUT_W-1:0] md_pack_word(
    input logic [STEP_W-1:0] step,
    input logic [IDX_W-1:0]  idx,
    input logic [REC_W-1:0]  rec
  );
    logic [OUT_W-1:0] w;
    w                             = '0;
    w[REC_LSB  +: REC_W]          = rec;
    w[IDX_LSB  +: IDX_W]          = idx;
    w[STEP_LSB +: STEP_W]         = step;
    w[PAD_LSB  +: OUT_W-PAD_LSB]  = '0;
    return w;
  endfunction

endpackage

// File: rtl/md_rb_timeout.sv
// Loadable down-counter that flags expiry once it has run down to zero
// while enabled; bounds the wait for an MD_Wrapper response.
module md_rb_timeout #(
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/md_readback_packer.sv
// Self-timed drain of MD_Wrapper particle records: issues read_ctrl pulses,
// tags each record with index and step, and streams 256-bit words out.
module md_readback_packer
  import md_pkg::*;
#(
  parameter int REC_W   = md_pkg::REC_W,
  parameter int OUT_W   = md_pkg::OUT_W,
  parameter int IDX_W   = md_pkg::IDX_W,
  parameter int TIMEOUT = 1024
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] n_particles,
  input  logic [31:0]      step,
  output logic             read_ctrl,
  input  logic             elem_read,
  input  logic [REC_W-1:0] d_out,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  md_state_t        r_state;
  md_state_t        w_next;
  logic [IDX_W-1:0] r_n;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_step;
  logic [OUT_W-1:0] r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic w_start_acc;
  logic w_capture;
  logic w_accept;
  logic w_last;
  logic w_expired;
  logic w_timeout;
  logic w_spurious;
  logic w_read_ctrl;
  logic w_tmo_load;
  logic w_tmo_en;

  assign w_start_acc = start && (r_state == ST_IDLE);
  assign w_capture   = (r_state == ST_WAIT) && elem_read;
  assign w_timeout   = (r_state == ST_WAIT) && !elem_read && w_expired;
  assign w_accept    = r_tvalid && m_tready;
  assign w_last      = (r_idx == r_n - IDX_W'(1));
  // A response strobe is only legitimate while a request is outstanding.
  assign w_spurious  = elem_read && r_busy && (r_state != ST_WAIT);

  md_rb_timeout #(
    .CNT_W (TMO_W)
  ) u_timeout (
    .i_clk      (ap_clk),
    .i_rst_n    (ap_rst_n),
    .i_load     (w_tmo_load),
    .i_load_val (TMO_W'(TIMEOUT - 1)),
    .i_en       (w_tmo_en),
    .o_expired  (w_expired)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_acc) w_next = (n_particles == '0) ? ST_FIN : ST_REQ;
      ST_REQ:  w_next = ST_WAIT;
      ST_WAIT: begin
        if (elem_read)      w_next = ST_SEND;
        else if (w_timeout) w_next = ST_FIN;
      end
      ST_SEND: if (w_accept) w_next = r_tlast ? ST_FIN : ST_REQ;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_read_ctrl = (r_state == ST_REQ);
    w_tmo_load  = (r_state == ST_REQ);
    w_tmo_en    = (r_state == ST_WAIT);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_idx  <= '0;
    end else begin
      r_done <= (r_state == ST_FIN);
      if (w_start_acc)               r_busy <= 1'b1;
      else if (r_state == ST_FIN)    r_busy <= 1'b0;
      if (w_start_acc)               r_err <= 1'b0;
      else if (w_timeout || w_spurious) r_err <= 1'b1;
      if (w_start_acc)               r_idx <= '0;
      else if ((r_state == ST_SEND) && w_accept) r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_n      <= '0;
      r_step   <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_n    <= n_particles;
        r_step <= step;
      end
      if (w_capture) begin
        r_tdata  <= md_pack_word(r_step, r_idx, d_out);
        r_tvalid <= 1'b1;
        r_tlast  <= w_last;
      end else if (w_accept) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  assign read_ctrl = w_read_ctrl;
  assign m_tdata   = r_tdata;
  assign m_tvalid  = r_tvalid;
  assign m_tlast   = r_tlast;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_md_readback_packer.sv
// Directed bench for md_readback_packer with an MD_Wrapper responder model
// and an expected-word queue checked at every output handshake.
module tb_md_readback_packer;

  localparam int REC_W = 192;
  localparam int OUT_W = 256;
  localparam int IDX_W = 16;
  localparam int TMO   = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] n_particles = '0;
  logic [31:0]      step = '0;
  logic             read_ctrl;
  logic             elem_read = 1'b0;
  logic [REC_W-1:0] d_out = '0;
  logic [OUT_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic             m_tlast;
  logic             busy;
  logic             done;
  logic             err;

  md_readback_packer #(
    .TIMEOUT (TMO)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .start       (start),
    .n_particles (n_particles),
    .step        (step),
    .read_ctrl   (read_ctrl),
    .elem_read   (elem_read),
    .d_out       (d_out),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [OUT_W-1:0] w;
    logic             last;
  } exp_t;

  exp_t             exp_q[$];
  int               total = 0;
  int               bad = 0;
  int               rc_cnt = 0;
  int               words = 0;
  int               lasts = 0;
  int               rsp_cnt = 0;
  int               rsp_lat = 2;
  int               drop_at = 0;
  bit               spur_req = 1'b0;
  logic [IDX_W-1:0] m_idx = '0;
  logic [IDX_W-1:0] m_n = '0;
  logic [31:0]      m_step = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_w(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // MD_Wrapper stand-in: answers each read_ctrl after rsp_lat cycles.
  always @(negedge ap_clk) begin : responder
    logic [REC_W-1:0] rec;
    elem_read = 1'b0;
    if (read_ctrl) begin
      rc_cnt++;
      if (rc_cnt != drop_at) rsp_cnt = rsp_lat;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        rec = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        d_out = rec;
        elem_read = 1'b1;
        exp_q.push_back('{w: {16'h0, m_step, m_idx, rec}, last: (m_idx == m_n - 16'd1)});
        m_idx = m_idx + 16'd1;
      end
    end else if (spur_req) begin
      d_out = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      elem_read = 1'b1;
      spur_req = 1'b0;
    end
  end

  always @(negedge ap_clk) begin : monitor
    exp_t e;
    if (ap_rst_n && m_tvalid && m_tready) begin
      chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_w("word", m_tdata, e.w);
        chk("tlast", 64'(m_tlast), 64'(e.last));
      end
      words++;
      if (m_tlast) lasts++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ap_clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge ap_clk);
    #2 m_tready = v;
  endtask

  task automatic begin_drain(input logic [IDX_W-1:0] n, input logic [31:0] s);
    m_idx = '0;
    m_n = n;
    m_step = s;
    rc_cnt = 0;
    words = 0;
    lasts = 0;
    n_particles = n;
    step = s;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done === 1'b1) break;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (m_tvalid === 1'b1) break;
    end
    chk(tag, 64'(m_tvalid), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_tready = 1'b1;
    tick(3);
    chk("rst_read_ctrl", 64'(read_ctrl), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk_w("rst_tdata", m_tdata, '0);
    ap_rst_n = 1'b1;
    tick(1);

    // Reset asserted while a word is waiting in SEND.
    set_ready(1'b0);
    tick(1);
    begin_drain(16'd3, 32'd7);
    wait_valid(50, "t1_valid");
    #1 ap_rst_n = 1'b0;
    #1;
    chk("t1_async_tvalid", 64'(m_tvalid), 64'd0);
    chk_w("t1_async_tdata", m_tdata, '0);
    chk("t1_async_busy", 64'(busy), 64'd0);
    chk("t1_async_tlast", 64'(m_tlast), 64'd0);
    chk("t1_async_err", 64'(err), 64'd0);
    exp_q.delete();
    tick(2);
    ap_rst_n = 1'b1;
    m_tready = 1'b1;
    tick(1);
    begin_drain(16'd2, 32'd8);
    wait_done(100, "t1_done");
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_words", 64'(words), 64'd2);
    chk("t1_reads", 64'(rc_cnt), 64'd2);

    // Plain drain of three records.
    tick(2);
    begin_drain(16'd3, 32'd1);
    chk("t2_rc_latency", 64'(read_ctrl), 64'd1);
    chk("t2_busy", 64'(busy), 64'd1);
    wait_done(200, "t2_done");
    chk("t2_reads", 64'(rc_cnt), 64'd3);
    chk("t2_words", 64'(words), 64'd3);
    chk("t2_lasts", 64'(lasts), 64'd1);
    chk("t2_busy_after", 64'(busy), 64'd0);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    tick(1);
    chk("t2_done_pulse", 64'(done), 64'd0);

    // Back-pressure on the second word.
    tick(2);
    begin_drain(16'd3, 32'd2);
    for (int i = 0; i < 100; i++) begin
      @(negedge ap_clk);
      #1;
      if (words >= 1) break;
    end
    set_ready(1'b0);
    wait_valid(50, "t3_valid");
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 64'(m_tvalid), 64'd1);
      chk_w("t3_hold_data", m_tdata, exp_q[0].w);
      chk("t3_no_req", 64'(read_ctrl), 64'd0);
      tick(1);
    end
    set_ready(1'b1);
    wait_done(200, "t3_done");
    chk("t3_reads", 64'(rc_cnt), 64'd3);
    chk("t3_words", 64'(words), 64'd3);
    chk("t3_lasts", 64'(lasts), 64'd1);

    // Empty drain.
    tick(2);
    begin_drain(16'd0, 32'd5);
    chk("t4_no_req", 64'(read_ctrl), 64'd0);
    chk("t4_done_early", 64'(done), 64'd0);
    tick(1);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_tvalid", 64'(m_tvalid), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_reads", 64'(rc_cnt), 64'd0);
    chk("t4_words", 64'(words), 64'd0);

    // Second request never answered.
    tick(2);
    drop_at = 2;
    begin_drain(16'd3, 32'd3);
    wait_done(200, "t5_done");
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_words", 64'(words), 64'd1);
    chk("t5_reads", 64'(rc_cnt), 64'd2);
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    drop_at = 0;
    tick(2);
    begin_drain(16'd1, 32'd4);
    chk("t5_err_cleared", 64'(err), 64'd0);
    wait_done(100, "t5_redo_done");
    chk("t5_redo_err", 64'(err), 64'd0);
    chk("t5_redo_words", 64'(words), 64'd1);

    // Spurious strobe and start while a word is held.
    tick(2);
    set_ready(1'b0);
    tick(1);
    begin_drain(16'd2, 32'd5);
    wait_valid(50, "t6_valid");
    spur_req = 1'b1;
    start = 1'b1;
    n_particles = 16'd7;
    step = 32'h99;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("t6_err", 64'(err), 64'd1);
    chk("t6_busy", 64'(busy), 64'd1);
    chk_w("t6_data_kept", m_tdata, exp_q[0].w);
    set_ready(1'b1);
    wait_done(200, "t6_done");
    chk("t6_words", 64'(words), 64'd2);
    chk("t6_reads", 64'(rc_cnt), 64'd2);
    chk("t6_lasts", 64'(lasts), 64'd1);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t6_err_sticky", 64'(err), 64'd1);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
